mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  - Shares the single-port 1024-word Memory between two requesters: the instruction-fetch port (I) and the load/store port (D).
//  - Sits between the CPU front/back ends and the Memory instance. Owns Memory ren/wen/addr/din exclusively.
//  - Guarantees ren and wen are never both high, and that exactly one access is in flight at a time.
//  - Returns read data and a one-cycle ack to the winning requester.
// PARAMETERS
//  AW  32  address width (Memory uses addr[9:0]; upper bits are passed through unchanged)
//  DW  32  data width
// PORTS
//  clock      in   1   system clock; all state updates on posedge
//  reset      in   1   asynchronous, active-low; 0 = reset
//  i_req      in   1   fetch request; held with i_addr until i_ack
//  i_addr     in   AW  fetch address
//  i_ack      out  1   one-cycle pulse; i_rdata valid in the same cycle
//  i_rdata    out  DW  fetched word (registered)
//  d_req      in   1   data request; held with d_we/d_addr/d_wdata until d_ack
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_ack      out  1   one-cycle pulse; d_rdata valid in the same cycle for loads
//  d_rdata    out  DW  loaded word (registered; unchanged on stores)
//  mem_ren    out  1   Memory read enable (registered)
//  mem_wen    out  1   Memory write enable (registered)
//  mem_addr   out  AW  Memory address (registered)
//  mem_din    out  DW  Memory write data (registered)
//  mem_dout   in   DW  Memory read data (combinational from Memory)
// BEHAVIOUR
//  - States: IDLE -> ACC_I | ACC_D -> DONE -> IDLE. Encoding is 2 bits: IDLE=0, ACC_I=1, ACC_D=2, DONE=3.
//  - IDLE: sample i_req/d_req at posedge. With no request, stay in IDLE.
//    - With a request: enter ACC_x, register mem_addr/mem_din.
//    - mem_ren = ~we and mem_wen = we, where we = 0 for the I port.
//  - ACC_x (1 cycle): Memory writes on the negedge inside this cycle.
//    - At the closing posedge: capture mem_dout into x_rdata (loads/fetches only), then go to DONE.
//    - On that same edge, drop mem_ren/mem_wen to 0, set x_ack=1, and record last_grant.
//  - DONE (1 cycle): x_ack=1, enables 0. At the next posedge, x_ack returns to 0 and the state returns to IDLE.
//  - Latency: req seen at edge E -> enable high during E..E+1 -> ack high during E+1..E+2. Three cycles per access.
//  - Requester must deassert req at the edge ending its ack cycle. A req still high in IDLE is a new access.
//  - Non-granted requester waits. Its req and payload must stay stable; it is not dropped.
//  - Simultaneous i_req & d_req: winner is chosen per CONFIGURATION. The loser is served in the very next IDLE.
//  - ren & wen: at most one is 1 in every state, by construction.
//  - Reset (any time, incl. mid-access) forces the following:
//    - state=IDLE, mem_ren=mem_wen=0, mem_addr=mem_din=0, i_ack=d_ack=0, i_rdata=d_rdata=0, last_grant=I.
//    - A store whose negedge has not yet occurred is dropped.
//  - Address bits [AW-1:10] are forwarded untouched. Wrap-around is the Memory's behaviour, not handled here.
// CONFIGURATION
//  - Macro ARB_ROUND_ROBIN_EN:
//    - Defined: on a tie, grant the port that did not win last (last_grant flips on each grant).
//    - Undefined: fixed priority, D beats I on every tie; last_grant is still kept but unused.
//  - The default build leaves the macro undefined.
// STRUCTURE
//  - Shared header constants.h: state encodings (ARB_IDLE/ARB_ACC_I/ARB_ACC_D/ARB_DONE) and requester IDs (ARB_ID_I=0, ARB_ID_D=1).
//  - One sub-module, arb_pick: combinational (i_req, d_req, last_grant) -> (grant_valid, grant_id). It holds the ifdef.
//  - The top module holds the FSM, the output registers and the ack/rdata capture.
// TESTING
//  1. Reset: hold reset=0 mid ACC_D store (addr 5, data 32'hDEAD) -> enables 0, acks 0, rdata 0; mem[5] unchanged after release.
//  2. Lone fetch: mem[3]=32'h1234_5678, i_req addr 3 at edge 0 -> mem_ren=1 during cycle 1.
//     -> i_ack=1 with i_rdata=32'h1234_5678 during cycle 2, then 0.
//  3. Store then load: d_we=1 addr 7 data 32'hA5A5_A5A5, then d_we=0 addr 7.
//     -> second d_ack carries 32'hA5A5_A5A5; mem_wen=1 for exactly one cycle.
//  4. Tie, macro undefined: i_req & d_req both high at edge 0 -> D acked cycle 2, I acked cycle 5. Repeat tie -> D first again.
//  5. Tie, ARB_ROUND_ROBIN_EN defined, after one D grant -> I wins the next tie, then D. Grants strictly alternate over 8 ties.
//  6. Invariant checker on every cycle: !(mem_ren & mem_wen); at most one ack high.
//     - Check 3-cycle latency for each access.
//     - Check that a held req is never lost over 200 random req cycles.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: FSM state encoding and requester IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ACC_I = 2'd1,
    ARB_ACC_D = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam logic ARB_ID_I = 1'b0;
  localparam logic ARB_ID_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant selection between fetch (I) and load/store (D) requests.
// ARB_ROUND_ROBIN_EN selects alternating ties; otherwise D wins every tie.
module mem_port_arbiter_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic last_grant_i,
  output logic grant_valid_c_o,
  output logic grant_id_c_o
);

  always_comb begin
    grant_valid_c_o = i_req_i | d_req_i;
    grant_id_c_o    = ARB_ID_I;
    if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      // Tie goes to whichever port did not win the previous access.
      grant_id_c_o = (last_grant_i == ARB_ID_D) ? ARB_ID_I : ARB_ID_D;
`else
      grant_id_c_o = ARB_ID_D;
`endif
    end else if (d_req_i) begin
      grant_id_c_o = ARB_ID_D;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  // History is tracked by the top but has no effect under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between fetch (I) and load/store (D) requesters,
// one access in flight at a time. Tie policy set by ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  arb_state_e    state_q, state_d;
  logic          mem_ren_q, mem_ren_d;
  logic          mem_wen_q, mem_wen_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          last_grant_q, last_grant_d;

  logic          grant_valid_c;
  logic          grant_id_c;

  mem_port_arbiter_arb_pick u_arb_pick (
    .i_req_i         (i_req),
    .d_req_i         (d_req),
    .last_grant_i    (last_grant_q),
    .grant_valid_c_o (grant_valid_c),
    .grant_id_c_o    (grant_id_c)
  );

  // State and output registers; reset also kills a pending store's enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      last_grant_q <= ARB_ID_I;
    end else begin
      state_q      <= state_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: enables live only for the ACC cycle, ack only for the DONE cycle.
  always_comb begin
    state_d      = state_q;
    mem_ren_d    = 1'b0;
    mem_wen_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    last_grant_d = last_grant_q;

    case (state_q)
      ARB_IDLE: begin
        if (grant_valid_c) begin
          if (grant_id_c == ARB_ID_D) begin
            state_d    = ARB_ACC_D;
            mem_addr_d = d_addr;
            mem_din_d  = d_wdata;
            mem_ren_d  = ~d_we;
            mem_wen_d  = d_we;
          end else begin
            state_d    = ARB_ACC_I;
            mem_addr_d = i_addr;
            mem_din_d  = '0;
            mem_ren_d  = 1'b1;
          end
        end
      end
      ARB_ACC_I: begin
        i_rdata_d    = mem_dout;
        i_ack_d      = 1'b1;
        last_grant_d = ARB_ID_I;
        state_d      = ARB_DONE;
      end
      ARB_ACC_D: begin
        // Stores leave the last loaded word in place.
        if (mem_ren_q) begin
          d_rdata_d = mem_dout;
        end
        d_ack_d      = 1'b1;
        last_grant_d = ARB_ID_D;
        state_d      = ARB_DONE;
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign mem_ren  = mem_ren_q;
  assign mem_wen  = mem_wen_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign i_ack    = i_ack_q;
  assign d_ack    = d_ack_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
